// File: rtl/conv_window_feeder.sv
// Streams a raster feature map through K-1 line buffers and emits every KxK window
// (stride 1, no padding). Define CONV_FEEDER_WIN_COUNT_EN to add the win_count output.
module conv_window_feeder #(
  parameter int DATA_W = 16,
  parameter int K      = 5,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic signed [DATA_W-1:0] window [K-1:0][K-1:0],
  output logic                     window_valid,
  input  logic                     window_ready,
  output logic                     start,
  output logic                     frame_done
`ifdef CONV_FEEDER_WIN_COUNT_EN
  ,
  output logic [15:0]              win_count
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);

  typedef enum logic [1:0] {S_FILL, S_ACTIVE, S_HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            win_valid_q, win_valid_d;
  logic            win_last_q, win_last_d;
  logic            frame_done_q, frame_done_d;
  logic            win_phase;
  logic            accept, produce, handshake, row_end, frame_end;

  // lb_q[0] holds the oldest buffered row, lb_q[K-2] the row just above the current one.
  logic signed [DATA_W-1:0] lb_q    [K-1][IMG_W];
  logic signed [DATA_W-1:0] win_q   [K-1:0][K-1:0];
  logic signed [DATA_W-1:0] col_vec [K];

  assign pix_ready = !rst && !(win_valid_q && !window_ready);
  assign accept    = pix_valid && pix_ready;
  assign handshake = win_valid_q && window_ready;
  assign row_end   = (col_q == COL_LAST);
  assign frame_end = row_end && (row_q == ROW_LAST);
  assign produce   = accept && win_phase && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_FILL:   if (accept && row_end && (row_q == ROW_FILL_LAST)) state_d = S_ACTIVE;
      S_ACTIVE: if (win_valid_q && !window_ready)                  state_d = S_HOLD;
                else if (handshake && win_last_q)                  state_d = S_FILL;
      S_HOLD:   if (window_ready) state_d = win_last_q ? S_FILL : S_ACTIVE;
      default:  state_d = S_FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    win_phase = (state_q != S_FILL);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      col_d = row_end ? '0 : col_q + 1'b1;
      if (row_end) row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
    // A fresh window takes priority over retiring the one being handshaken.
    win_valid_d  = produce || (win_valid_q && !window_ready);
    win_last_d   = produce ? frame_end : win_last_q;
    frame_done_d = handshake && win_last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    for (int k = 0; k < K - 1; k++) col_vec[k] = lb_q[k][col_q];
    col_vec[K-1] = pix_in;
  end

  // NOTE: line-buffer storage is deliberately not reset; rows are rewritten before any window uses them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < K - 2; k++) lb_q[k][col_q] <= lb_q[k+1][col_q];
      lb_q[K-2][col_q] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) win_q[i][j] <= '0;
    end else if (accept) begin
      for (int i = 0; i < K; i++) begin
        for (int j = 0; j < K - 1; j++) win_q[i][j] <= win_q[i][j+1];
        win_q[i][K-1] <= col_vec[i];
      end
    end
  end

`ifdef CONV_FEEDER_WIN_COUNT_EN
  logic [15:0] win_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_count_q <= '0;
    else     win_count_q <= (frame_done_q ? 16'd0 : win_count_q) + {15'd0, handshake};
  end

  assign win_count = win_count_q;
`endif

  assign window       = win_q;
  assign window_valid = win_valid_q;
  assign start        = win_valid_q;
  assign frame_done   = frame_done_q;

endmodule
